// File: rtl/mem_master.sv
// mem_master: MAR/MDR owner that sequences single-word read/write strobes to the synchronous ram.
module mem_master #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              mem_req,
  input  logic              mem_we,
  output logic              mem_done,
  output logic              busy,
  output logic              req_dropped,
  output logic [DATA_W-1:0] MDR_q,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [2:0] lat_cnt;
  logic accept, capture;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = mem_req ? (mem_we ? WRITE : READ) : IDLE;
      WRITE:      next = DONE;
      READ:       next = WAIT;
      WAIT:       next = (lat_cnt == 3'd0) ? DONE : WAIT;
      default:    next = IDLE;
    endcase
  end
  assign accept    = (state == IDLE) || (state == DONE);
  assign capture   = (state == WAIT) && (lat_cnt == 3'd0);
  assign busy      = (state == WRITE) || (state == READ) || (state == WAIT);
  assign ram_read  = state == READ;
  assign ram_write = state == WRITE;
  assign mem_done  = state == DONE;
  assign ram_addr  = mar;
  assign ram_wdata = mdr;
  assign MDR_q     = mdr;
  // MAR/MDR are frozen while busy so the ram sees stable address and data.
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      state       <= IDLE;
      mar         <= '0;
      mdr         <= '0;
      lat_cnt     <= '0;
      req_dropped <= 1'b0;
    end else begin
      state       <= next;
      req_dropped <= mem_req & busy;
      if (accept && MARin) mar <= BusMuxOut[ADDR_W-1:0];
      if (capture) mdr <= ram_rdata;
      else if (accept && MDRin) mdr <= BusMuxOut;
      if (state == READ) lat_cnt <= 3'(READ_LAT - 1);
      else if (state == WAIT && lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
    end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed checks of mem_master against behavioural rams with 1- and 3-cycle read latency.
module tb_mem_master;
  logic clock = 0, clear_n = 0, preload = 0;
  logic [31:0] bus = '0;
  logic MARin = 0, MDRin = 0, mem_req = 0, mem_we = 0;
  logic d1_done, d1_busy, d1_drop, d1_rd, d1_wr;
  logic d2_done, d2_busy, d2_drop, d2_rd, d2_wr;
  logic [31:0] d1_mdr, d1_wdata, d1_rdata, d2_mdr, d2_wdata, d2_rdata;
  logic [8:0] d1_addr, d2_addr;
  logic [31:0] mem1 [512];
  logic [31:0] mem2 [512];
  logic [31:0] pipe2 [3];
  int pass_cnt = 0, total = 0, wcnt = 0, n, w0;
  logic seen;

  always #5 clock = ~clock;

  mem_master #(.READ_LAT(1)) u1 (
    .clock(clock), .clear_n(clear_n), .BusMuxOut(bus), .MARin(MARin), .MDRin(MDRin),
    .mem_req(mem_req), .mem_we(mem_we), .mem_done(d1_done), .busy(d1_busy),
    .req_dropped(d1_drop), .MDR_q(d1_mdr), .ram_read(d1_rd), .ram_write(d1_wr),
    .ram_addr(d1_addr), .ram_wdata(d1_wdata), .ram_rdata(d1_rdata));

  mem_master #(.READ_LAT(3)) u2 (
    .clock(clock), .clear_n(clear_n), .BusMuxOut(bus), .MARin(MARin), .MDRin(MDRin),
    .mem_req(mem_req), .mem_we(mem_we), .mem_done(d2_done), .busy(d2_busy),
    .req_dropped(d2_drop), .MDR_q(d2_mdr), .ram_read(d2_rd), .ram_write(d2_wr),
    .ram_addr(d2_addr), .ram_wdata(d2_wdata), .ram_rdata(d2_rdata));

  // Read data is valid only in the exact cycle the latency promises; poison otherwise.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) begin
        mem1[i] <= 32'(2 * i + 6);
        mem2[i] <= 32'(2 * i + 6);
      end
    end else begin
      if (d1_wr) mem1[d1_addr] <= d1_wdata;
      if (d2_wr) mem2[d2_addr] <= d2_wdata;
    end
    d1_rdata <= d1_rd ? mem1[d1_addr] : 32'hBAD0BAD0;
    pipe2[0] <= d2_rd ? mem2[d2_addr] : 32'hBAD0BAD0;
    pipe2[1] <= pipe2[0];
    pipe2[2] <= pipe2[1];
  end
  assign d2_rdata = pipe2[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clock);
    @(negedge clock);
    if (d1_wr) wcnt++;
  endtask

  task automatic request(input logic [31:0] b, input logic mar, input logic mdr, input logic we);
    bus = b;
    MARin = mar;
    MDRin = mdr;
    mem_req = 1;
    mem_we = we;
    step();
    MARin = 0;
    MDRin = 0;
    mem_req = 0;
  endtask

  task automatic wait_done(input bit sel, output int cnt);
    cnt = 1;
    while (!(sel ? d2_done : d1_done) && cnt < 20) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    bus = $urandom;
    MARin = 1;
    MDRin = 1;
    mem_req = 1;
    mem_we = 1'($urandom);
    preload = 1;
    repeat (3) @(negedge clock);
    chk("rst_mdr", d1_mdr, 32'h0);
    chk("rst_addr", 32'(d1_addr), 32'h0);
    chk("rst_wdata", d1_wdata, 32'h0);
    chk("rst_ctl", 32'({d1_rd, d1_wr, d1_done, d1_busy, d1_drop, d2_rd, d2_wr, d2_done, d2_busy, d2_drop}), 32'h0);
    clear_n = 1;
    preload = 0;
    MARin = 0;
    MDRin = 0;
    mem_req = 0;
    seen = 0;
    repeat (5) begin
      step();
      seen |= d1_rd | d1_wr | d2_rd | d2_wr;
    end
    chk("idle_strobe", 32'(seen), 32'h0);

    request(32'd71, 1, 0, 0);
    chk("pre_rd_strobe", 32'(d1_rd), 32'h1);
    chk("pre_addr", 32'(d1_addr), 32'd71);
    wait_done(0, n);
    chk("pre_lat", n, 32'd3);
    chk("pre_data", d1_mdr, 32'h94);
    step();
    chk("done_pulse", 32'(d1_done), 32'h0);
    repeat (3) step();

    bus = 32'h047;
    MARin = 1;
    step();
    MARin = 0;
    w0 = wcnt;
    request(32'hDEADBEEF, 0, 1, 1);
    chk("wr_strobe", 32'({d1_wr, d1_rd, d1_busy}), 32'h5);
    chk("wr_addr", 32'(d1_addr), 32'h047);
    chk("wr_wdata", d1_wdata, 32'hDEADBEEF);
    wait_done(0, n);
    chk("wr_lat", n, 32'd2);
    step();
    chk("wr_count", wcnt - w0, 32'd1);
    repeat (2) step();
    bus = 32'h0;
    MDRin = 1;
    step();
    MDRin = 0;
    chk("mdr_load", d1_mdr, 32'h0);
    request(32'h0, 0, 0, 0);
    wait_done(0, n);
    chk("rb_lat", n, 32'd3);
    chk("rb_data", d1_mdr, 32'hDEADBEEF);
    repeat (4) step();

    request(32'd5, 1, 0, 0);
    wait_done(1, n);
    chk("lat3_lat", n, 32'd5);
    chk("lat3_data", d2_mdr, 32'd16);
    repeat (3) step();

    bus = 32'h010;
    MARin = 1;
    step();
    MARin = 0;
    w0 = wcnt;
    request(32'h0, 0, 0, 1);
    chk("busy_wr", 32'(d1_busy), 32'h1);
    request(32'h1FF, 1, 0, 0);
    chk("busy_drop", 32'(d1_drop), 32'h1);
    chk("busy_mar", 32'(d1_addr), 32'h010);
    chk("busy_done", 32'(d1_done), 32'h1);
    step();
    chk("busy_drop_end", 32'(d1_drop), 32'h0);
    chk("busy_mar_end", 32'(d1_addr), 32'h010);
    chk("busy_wcount", wcnt - w0, 32'd1);
    repeat (4) step();

    for (int i = 0; i < 3; i++) begin
      request(32'(i), 1, 0, 0);
      chk("b2b_rd", 32'({d1_rd, d1_drop}), 32'h2);
      wait_done(0, n);
      chk("b2b_lat", n, 32'd3);
      chk("b2b_data", d1_mdr, 32'(2 * i + 6));
    end
    repeat (5) step();

    request(32'd1, 1, 0, 0);
    step();
    chk("abort_wait", 32'({d1_busy, d1_done}), 32'h2);
    #1 clear_n = 0;
    #1;
    chk("abort_mdr", d1_mdr, 32'h0);
    chk("abort_ctl", 32'({d1_busy, d1_done, d1_rd}), 32'h0);
    step();
    step();
    clear_n = 1;
    seen = 0;
    repeat (4) begin
      step();
      seen |= d1_done | d1_rd | d1_wr | d1_busy;
    end
    chk("abort_quiet", 32'(seen), 32'h0);
    chk("abort_mdr_end", d1_mdr, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mem_master.md
# mem_master

Memory-side bus master for the mini CPU. It owns the MAR and MDR, accepts single-word read/write requests from the control unit and sequences the strobes to the synchronous `ram` block. It also absorbs the RAM's registered read latency and returns read data through the MDR with a one-cycle completion pulse. It sits between the datapath bus (`BusMuxOut`) and the `ram` instance, replacing direct control-unit drive of `read`/`write`/`addr`.

## Interface
- `ADDR_W`, 9, MAR width; RAM word-address width.
- `DATA_W`, 32, data width of bus, MDR and RAM.
- `READ_LAT`, 1, cycles from the edge that samples `ram_read` until `ram_rdata` is valid; legal range 1–7.
- `clock`  in  1  sole clock, rising edge.
- `clear_n`  in  1  asynchronous active-low reset.
- `BusMuxOut`  in  DATA_W  datapath bus.
- `MARin`  in  1  load MAR from `BusMuxOut[ADDR_W-1:0]`.
- `MDRin`  in  1  load MDR from `BusMuxOut`.
- `mem_req`  in  1  request strobe; sampled each edge.
- `mem_we`  in  1  qualifies `mem_req`: 1 = write, 0 = read.
- `mem_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  transaction in flight.
- `req_dropped`  out  1  one-cycle pulse: `mem_req` ignored.
- `MDR_q`  out  DATA_W  MDR contents, to the bus mux.
- `ram_read`  out  1  to `ram.read`.
- `ram_write`  out  1  to `ram.write`.
- `ram_addr`  out  ADDR_W  to `ram.addr`; always equals MAR.
- `ram_wdata`  out  DATA_W  to `ram.BusMuxOut`; always equals MDR.
- `ram_rdata`  in  DATA_W  from `ram.MDataIn`.

## Operation
- States: IDLE, WRITE, READ, WAIT, DONE.
- IDLE and DONE accept requests:
  - `mem_req & mem_we` goes to WRITE.
  - `mem_req & ~mem_we` goes to READ.
  - Otherwise the next state is IDLE.
- WRITE: `ram_write`=1 for exactly one cycle, then DONE.
- READ: `ram_read`=1 for exactly one cycle, then WAIT with `lat_cnt` loaded to `READ_LAT-1`.
- WAIT: decrement `lat_cnt`. In the cycle where `lat_cnt`==0, MDR <= `ram_rdata` at the closing edge, then DONE.
- DONE: `mem_done`=1 for one cycle.
- `ram_read`, `ram_write`, `mem_done` and `busy` are decoded from the state register only. They never depend on inputs combinationally.
- `ram_read` and `ram_write` are never both 1.
- `busy` = state ∈ {WRITE, READ, WAIT}.
- MARin and MDRin take effect only when state ∈ {IDLE, DONE}. When `busy` they are ignored, so address and write data stay stable through the transaction.
- A read's MDR capture has priority; `MDRin` cannot coincide with it because it is ignored while busy.
- Same-edge `MARin` + `mem_req`: the transaction uses the newly loaded MAR.
- Same-edge `MDRin` + write request: the newly loaded MDR is written.
- `mem_req` while `busy`: request discarded, and `req_dropped`=1 in the next cycle. There is no queueing.
- `mem_we` is don't-care when `mem_req`=0.

## Timing
- Reset (`clear_n`=0, asynchronous, any state):
  - state=IDLE, MAR=0, MDR=0, `lat_cnt`=0.
  - All outputs 0: `ram_addr`=0, `ram_wdata`=0, `MDR_q`=0.
  - No RAM strobe is issued after reset release until a new request is accepted.
- Write: request sampled at edge E0; WRITE in cycle E0–E1 (RAM stores at E1); `mem_done` in cycle E1–E2. Latency is 2 cycles.
- Read: request at E0; READ cycle E0–E1; WAIT for `READ_LAT` cycles; DONE cycle with MDR valid. Latency is `READ_LAT`+2 cycles (3 at default).
- Back-to-back: a request sampled in the DONE cycle starts the next transaction with no IDLE bubble. Sustained throughput is one write per 2 cycles and one read per `READ_LAT`+2 cycles.
- Reset mid-transaction aborts it. No `mem_done` is generated and MDR reads 0.

## Test plan
- Reset: hold `clear_n`=0 with random inputs → all outputs 0; after release with `mem_req`=0 for 5 cycles, `ram_read`/`ram_write` stay 0.
- Write then read: MARin with bus=0x047, MDRin with bus=0xDEADBEEF, write request → `ram_write` high 1 cycle at addr 0x047 and `mem_done` 2 cycles after the request. Then MDRin 0 and a read request → `mem_done` 3 cycles after the request, `MDR_q`=0xDEADBEEF.
- Preload: read addr 71 against preloaded RAM → `MDR_q`=0x94.
- Latency: with `READ_LAT`=3 and a delayed RAM model → `mem_done` 5 cycles after the request and the correct data captured.
- Busy handling: write request, then `mem_req`+`MARin`(bus=0x1FF) one cycle later → `req_dropped` pulses, MAR unchanged, exactly one `ram_write`.
- Back-to-back: reads issued in each DONE cycle to addrs 0, 1, 2 → `mem_done` every 3 cycles and `MDR_q` sequence mem[0], mem[1], mem[2].
- Abort: assert `clear_n`=0 during WAIT → MDR=0, no `mem_done`, state IDLE.
